// File: rtl/fighter_anim_pkg.sv
// Shared types and tables for the fighter animation controller and its sprite
// address generator: animation enum, per-animation frame counts, sheet bases.
package fighter_anim_pkg;

  localparam int ROM_AW = 17;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WALK  = 3'd1,
    PUNCH = 3'd2,
    KICK  = 3'd3,
    HIT   = 3'd4,
    DEAD  = 3'd5
  } anim_t;

  function automatic logic [2:0] frame_count(input anim_t a);
    case (a)
      IDLE:    frame_count = 3'd4;
      WALK:    frame_count = 3'd4;
      PUNCH:   frame_count = 3'd3;
      KICK:    frame_count = 3'd3;
      HIT:     frame_count = 3'd2;
      DEAD:    frame_count = 3'd4;
      default: frame_count = 3'd1;
    endcase
  endfunction

  function automatic logic [ROM_AW-1:0] sheet_base(input anim_t a);
    case (a)
      IDLE:    sheet_base = 17'd0;
      WALK:    sheet_base = 17'd16384;
      PUNCH:   sheet_base = 17'd32768;
      KICK:    sheet_base = 17'd45056;
      HIT:     sheet_base = 17'd57344;
      DEAD:    sheet_base = 17'd65536;
      default: sheet_base = 17'd0;
    endcase
  endfunction

endpackage

// File: rtl/fighter_anim_seq_addr.sv
// Registered sprite-ROM address and in-box flag for a 64x64 sprite at (pos_x,pos_y).
// FIGHTER_ANIM_MIRROR_EN enables horizontal mirroring through i_facing_left.
module fighter_sprite_addr
  import fighter_anim_pkg::*;
#(
  parameter int SPR_DIM = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  anim_t             i_anim,
  input  logic [1:0]        i_frame,
  input  logic              i_facing_left,
  input  logic [9:0]        i_pos_x,
  input  logic [9:0]        i_pos_y,
  input  logic [9:0]        i_draw_x,
  input  logic [9:0]        i_draw_y,
  output logic [ROM_AW-1:0] o_rom_address,
  output logic              o_in_sprite
);

  localparam logic signed [10:0] DIM_S = 11'(SPR_DIM);

  logic signed [10:0] w_rx_p0;
  logic signed [10:0] w_ry_p0;
  logic signed [10:0] w_col_p0;
  logic               w_in_p0;
  logic [ROM_AW-1:0]  w_addr_p0;

  // Stage p0: signed offsets keep partly off-screen sprites from wrapping
  assign w_rx_p0 = $signed({1'b0, i_draw_x}) - $signed({1'b0, i_pos_x});
  assign w_ry_p0 = $signed({1'b0, i_draw_y}) - $signed({1'b0, i_pos_y});
  assign w_in_p0 = !w_rx_p0[10] && (w_rx_p0 < DIM_S) &&
                   !w_ry_p0[10] && (w_ry_p0 < DIM_S);

`ifdef FIGHTER_ANIM_MIRROR_EN
  assign w_col_p0 = i_facing_left ? (DIM_S - 11'sd1 - w_rx_p0) : w_rx_p0;
`else
  logic w_unused_facing;
  assign w_unused_facing = i_facing_left;
  assign w_col_p0        = w_rx_p0;
`endif

  assign w_addr_p0 = sheet_base(i_anim)
                   + (ROM_AW'(i_frame) * ROM_AW'(SPR_DIM * SPR_DIM))
                   + (ROM_AW'(w_ry_p0) * ROM_AW'(SPR_DIM))
                   + ROM_AW'(w_col_p0);

  // Stage p1: registered outputs, sampled by the ROM on the following negedge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rom_address <= '0;
      o_in_sprite   <= 1'b0;
    end else if (w_in_p0) begin
      o_rom_address <= w_addr_p0;
      o_in_sprite   <= 1'b1;
    end else begin
      o_rom_address <= '0;
      o_in_sprite   <= 1'b0;
    end
  end

endmodule

// File: rtl/fighter_anim_seq.sv
// Per-fighter animation FSM with frame pacing and attack handshake, driving the
// sprite address generator. FIGHTER_ANIM_MIRROR_EN enables facing_left mirroring.
module fighter_anim_seq
  import fighter_anim_pkg::*;
#(
  parameter int FRAME_HOLD = 6,
  parameter int SPR_DIM    = 64
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              walk,
  input  logic              act_valid,
  input  logic              act_kind,
  output logic              act_ready,
  input  logic              hit,
  input  logic              health_zero,
  input  logic              facing_left,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ROM_AW-1:0] rom_address,
  output logic              in_sprite,
  output logic [2:0]        anim,
  output logic              act_done
);

  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);

  anim_t             r_anim;
  logic [1:0]        r_frame;
  logic [HOLD_W-1:0] r_hold;
  logic              r_act_done;

  anim_t      w_rest;
  logic       w_ready;
  logic       w_accept;
  logic       w_hold_wrap;
  logic [2:0] w_last_idx;
  logic       w_last;

  assign w_rest      = walk ? WALK : IDLE;
  assign w_ready     = ((r_anim == IDLE) || (r_anim == WALK)) && !health_zero && !hit;
  assign w_accept    = act_valid && w_ready;
  assign w_hold_wrap = (r_hold == HOLD_LAST);
  assign w_last_idx  = frame_count(r_anim) - 3'd1;
  assign w_last      = ({1'b0, r_frame} == w_last_idx);

  // Every state entry clears frame and hold, overriding a coincident frame_tick
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_anim     <= IDLE;
      r_frame    <= '0;
      r_hold     <= '0;
      r_act_done <= 1'b0;
    end else begin
      r_act_done <= 1'b0;
      if (health_zero && (r_anim != DEAD)) begin
        r_anim  <= DEAD;
        r_frame <= '0;
        r_hold  <= '0;
      end else if (hit && (r_anim != DEAD)) begin
        r_anim  <= HIT;
        r_frame <= '0;
        r_hold  <= '0;
      end else if (w_accept) begin
        r_anim  <= act_kind ? KICK : PUNCH;
        r_frame <= '0;
        r_hold  <= '0;
      end else begin
        case (r_anim)
          IDLE, WALK: begin
            if (r_anim != w_rest) begin
              r_anim  <= w_rest;
              r_frame <= '0;
              r_hold  <= '0;
            end else if (frame_tick) begin
              if (w_hold_wrap) begin
                r_hold  <= '0;
                r_frame <= w_last ? 2'd0 : r_frame + 2'd1;
              end else begin
                r_hold <= r_hold + 1'b1;
              end
            end
          end
          PUNCH, KICK, HIT: begin
            if (frame_tick) begin
              if (w_hold_wrap) begin
                r_hold <= '0;
                if (w_last) begin
                  r_anim     <= w_rest;
                  r_frame    <= '0;
                  r_act_done <= 1'b1;
                end else begin
                  r_frame <= r_frame + 2'd1;
                end
              end else begin
                r_hold <= r_hold + 1'b1;
              end
            end
          end
          DEAD: begin
            if (frame_tick) begin
              if (w_hold_wrap) begin
                r_hold <= '0;
                if (!w_last) r_frame <= r_frame + 2'd1;
              end else begin
                r_hold <= r_hold + 1'b1;
              end
            end
          end
          default: begin
            r_anim  <= IDLE;
            r_frame <= '0;
            r_hold  <= '0;
          end
        endcase
      end
    end
  end

  fighter_sprite_addr #(
    .SPR_DIM (SPR_DIM)
  ) u_addr (
    .i_clk         (vga_clk),
    .i_rst         (reset),
    .i_anim        (r_anim),
    .i_frame       (r_frame),
    .i_facing_left (facing_left),
    .i_pos_x       (pos_x),
    .i_pos_y       (pos_y),
    .i_draw_x      (DrawX),
    .i_draw_y      (DrawY),
    .o_rom_address (rom_address),
    .o_in_sprite   (in_sprite)
  );

  assign act_ready = w_ready;
  assign anim      = r_anim;
  assign act_done  = r_act_done;

endmodule

// File: tb/tb_fighter_anim_seq.sv
// Bench for fighter_anim_seq: directed scenarios plus randomized traffic checked
// against a tick-count reference model of the animation rules.
module tb_fighter_anim_seq;

  localparam int FH = 6;
`ifdef FIGHTER_ANIM_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif
  localparam int A_IDLE = 0, A_WALK = 1, A_PUNCH = 2, A_KICK = 3, A_HIT = 4, A_DEAD = 5;

  logic        vga_clk = 1'b0;
  logic        reset, frame_tick, walk, act_valid, act_kind, hit, health_zero, facing_left;
  logic [9:0]  pos_x, pos_y, DrawX, DrawY;
  logic        act_ready, in_sprite, act_done;
  logic [16:0] rom_address;
  logic [2:0]  anim;

  int checks = 0;
  int failures = 0;
  int m_anim, m_ticks;
  bit m_done;
  int e_addr;
  bit e_in;

  fighter_anim_seq #(.FRAME_HOLD(FH), .SPR_DIM(64)) dut (
    .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick), .walk(walk),
    .act_valid(act_valid), .act_kind(act_kind), .act_ready(act_ready), .hit(hit),
    .health_zero(health_zero), .facing_left(facing_left), .pos_x(pos_x), .pos_y(pos_y),
    .DrawX(DrawX), .DrawY(DrawY), .rom_address(rom_address), .in_sprite(in_sprite),
    .anim(anim), .act_done(act_done)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic int base_of(input int a);
    case (a)
      A_IDLE: return 0;      A_WALK: return 16384;  A_PUNCH: return 32768;
      A_KICK: return 45056;  A_HIT:  return 57344;  default: return 65536;
    endcase
  endfunction

  function automatic int nfr(input int a);
    if (a == A_PUNCH || a == A_KICK) return 3;
    if (a == A_HIT) return 2;
    return 4;
  endfunction

  function automatic int m_frame();
    int f;
    f = m_ticks / FH;
    if (m_anim == A_IDLE || m_anim == A_WALK) return f % 4;
    if (m_anim == A_DEAD) return (f > 3) ? 3 : f;
    return f;
  endfunction

  function automatic bit m_ready();
    return (m_anim == A_IDLE || m_anim == A_WALK) && !health_zero && !hit;
  endfunction

  task automatic model_step();
    int rest;
    rest = walk ? A_WALK : A_IDLE;
    m_done = 1'b0;
    if (health_zero && m_anim != A_DEAD) begin m_anim = A_DEAD; m_ticks = 0; end
    else if (hit && m_anim != A_DEAD) begin m_anim = A_HIT; m_ticks = 0; end
    else if (act_valid && m_ready()) begin m_anim = act_kind ? A_KICK : A_PUNCH; m_ticks = 0; end
    else if (m_anim == A_IDLE || m_anim == A_WALK) begin
      if (m_anim != rest) begin m_anim = rest; m_ticks = 0; end
      else if (frame_tick) m_ticks++;
    end else if (m_anim == A_DEAD) begin
      if (frame_tick && m_ticks < 1000) m_ticks++;
    end else if (frame_tick) begin
      m_ticks++;
      if (m_ticks == nfr(m_anim) * FH) begin m_anim = rest; m_ticks = 0; m_done = 1'b1; end
    end
  endtask

  task automatic pix_expect();
    int rx, ry, col;
    rx = int'(DrawX) - int'(pos_x);
    ry = int'(DrawY) - int'(pos_y);
    e_in = (rx >= 0) && (rx < 64) && (ry >= 0) && (ry < 64);
    col = (MIRROR && facing_left) ? 63 - rx : rx;
    e_addr = e_in ? base_of(m_anim) + m_frame() * 4096 + ry * 64 + col : 0;
  endtask

  task automatic advance();
    pix_expect();
    model_step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic clear_inputs();
    frame_tick = 0; walk = 0; act_valid = 0; act_kind = 0; hit = 0;
    health_zero = 0; facing_left = 0; pos_x = 10'd100; pos_y = 10'd200;
    DrawX = 10'd100; DrawY = 10'd200;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_anim = A_IDLE; m_ticks = 0; m_done = 1'b0;
    @(posedge vga_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    checks++; if (anim !== 3'd0) begin failures++; $display("FAIL reset_anim got=%0d exp=0", anim); end
    checks++; if (rom_address !== 17'd0) begin failures++; $display("FAIL reset_rom got=%0d exp=0", rom_address); end
    checks++; if (in_sprite !== 1'b0) begin failures++; $display("FAIL reset_in_sprite got=%0d exp=0", in_sprite); end
    checks++; if (act_done !== 1'b0) begin failures++; $display("FAIL reset_act_done got=%0d exp=0", act_done); end
    checks++; if (act_ready !== 1'b1) begin failures++; $display("FAIL reset_act_ready got=%0d exp=1", act_ready); end
    @(posedge vga_clk); #1;
    checks++; if (rom_address !== 17'd0) begin failures++; $display("FAIL reset_hold_rom got=%0d exp=0", rom_address); end
    do_reset();
  endtask

  task automatic test_idle_frames();
    clear_inputs(); do_reset();
    frame_tick = 1; repeat (6) advance();
    frame_tick = 0; advance();
    checks++; if (anim !== 3'd0) begin failures++; $display("FAIL idle_anim got=%0d exp=0", anim); end
    checks++; if (rom_address !== 17'd4096) begin failures++; $display("FAIL idle_frame1 got=%0d exp=4096", rom_address); end
    frame_tick = 1; repeat (18) advance();
    frame_tick = 0; advance();
    checks++; if (rom_address !== 17'd0) begin failures++; $display("FAIL idle_wrap got=%0d exp=0", rom_address); end
  endtask

  task automatic test_punch();
    int ndone;
    clear_inputs(); do_reset();
    act_valid = 1; act_kind = 0; #1;
    checks++; if (act_ready !== 1'b1) begin failures++; $display("FAIL punch_ready_pre got=%0d exp=1", act_ready); end
    advance(); act_valid = 0; #1;
    checks++; if (anim !== 3'd2) begin failures++; $display("FAIL punch_anim got=%0d exp=2", anim); end
    checks++; if (act_ready !== 1'b0) begin failures++; $display("FAIL punch_ready_busy got=%0d exp=0", act_ready); end
    frame_tick = 1; ndone = 0;
    for (int i = 0; i < 18; i++) begin
      advance();
      if (act_done) ndone++;
      if (i == 16) begin
        checks++; if (anim !== 3'd2) begin failures++; $display("FAIL punch_tick17 got=%0d exp=2", anim); end
      end
    end
    checks++; if (anim !== 3'd0) begin failures++; $display("FAIL punch_end_anim got=%0d exp=0", anim); end
    checks++; if (act_done !== 1'b1) begin failures++; $display("FAIL punch_done got=%0d exp=1", act_done); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL punch_done_count got=%0d exp=1", ndone); end
    frame_tick = 0; advance();
    checks++; if (act_done !== 1'b0) begin failures++; $display("FAIL punch_done_pulse got=%0d exp=0", act_done); end
  endtask

  task automatic test_hit_during_kick();
    clear_inputs(); do_reset();
    walk = 1; advance();
    checks++; if (anim !== 3'd1) begin failures++; $display("FAIL kick_walk got=%0d exp=1", anim); end
    act_valid = 1; act_kind = 1; advance(); act_valid = 0;
    checks++; if (anim !== 3'd3) begin failures++; $display("FAIL kick_anim got=%0d exp=3", anim); end
    frame_tick = 1; repeat (6) advance();
    frame_tick = 0; advance();
    checks++; if (rom_address !== 17'd49152) begin failures++; $display("FAIL kick_frame1 got=%0d exp=49152", rom_address); end
    hit = 1; advance(); hit = 0;
    checks++; if (anim !== 3'd4) begin failures++; $display("FAIL hit_anim got=%0d exp=4", anim); end
    advance();
    checks++; if (rom_address !== 17'd57344) begin failures++; $display("FAIL hit_frame0 got=%0d exp=57344", rom_address); end
    frame_tick = 1; repeat (11) advance();
    checks++; if (act_done !== 1'b0) begin failures++; $display("FAIL hit_early_done got=%0d exp=0", act_done); end
    advance(); frame_tick = 0;
    checks++; if (act_done !== 1'b1) begin failures++; $display("FAIL hit_done got=%0d exp=1", act_done); end
    checks++; if (anim !== 3'd1) begin failures++; $display("FAIL hit_to_walk got=%0d exp=1", anim); end
  endtask

  task automatic test_dead();
    clear_inputs(); do_reset();
    health_zero = 1; hit = 1; act_valid = 1; #1;
    checks++; if (act_ready !== 1'b0) begin failures++; $display("FAIL dead_ready_pre got=%0d exp=0", act_ready); end
    advance(); health_zero = 0; hit = 0; #1;
    checks++; if (anim !== 3'd5) begin failures++; $display("FAIL dead_anim got=%0d exp=5", anim); end
    checks++; if (act_ready !== 1'b0) begin failures++; $display("FAIL dead_ready got=%0d exp=0", act_ready); end
    frame_tick = 1; repeat (30) advance();
    act_valid = 0; frame_tick = 0; hit = 1; advance(); hit = 0;
    checks++; if (anim !== 3'd5) begin failures++; $display("FAIL dead_sticky got=%0d exp=5", anim); end
    advance();
    checks++; if (rom_address !== 17'd77824) begin failures++; $display("FAIL dead_frame3 got=%0d exp=77824", rom_address); end
  endtask

  task automatic test_addr();
    int tdx[8] = '{100, 163, 164, 99, 100, 163, 100, 100};
    int tdy[8] = '{200, 200, 200, 200, 263, 263, 264, 199};
    bit tin[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int tnm[8] = '{0, 63, 0, 0, 4032, 4095, 0, 0};
    int tmr[8] = '{63, 0, 0, 0, 4095, 4032, 0, 0};
    int exp_rom;
    clear_inputs(); do_reset();
    for (int f = 0; f < 2; f++) begin
      facing_left = f[0];
      for (int i = 0; i < 8; i++) begin
        DrawX = 10'(tdx[i]); DrawY = 10'(tdy[i]);
        advance();
        exp_rom = (MIRROR && f == 1) ? tmr[i] : tnm[i];
        checks++; if (in_sprite !== tin[i]) begin failures++; $display("FAIL addr_in[%0d,%0d] got=%0d exp=%0d", f, i, in_sprite, tin[i]); end
        checks++; if (rom_address !== 17'(exp_rom)) begin failures++; $display("FAIL addr_rom[%0d,%0d] got=%0d exp=%0d", f, i, rom_address, exp_rom); end
      end
    end
  endtask

  task automatic test_offscreen();
    int tpx[4] = '{1000, 1000, 100, 0};
    int tpy[4] = '{200, 200, 1000, 200};
    int tdx[4] = '{10, 1023, 120, 1000};
    int tdy[4] = '{200, 210, 5, 200};
    bit tin[4] = '{0, 1, 0, 0};
    int trm[4] = '{0, 663, 0, 0};
    clear_inputs(); do_reset();
    for (int i = 0; i < 4; i++) begin
      pos_x = 10'(tpx[i]); pos_y = 10'(tpy[i]); DrawX = 10'(tdx[i]); DrawY = 10'(tdy[i]);
      advance();
      checks++; if (in_sprite !== tin[i]) begin failures++; $display("FAIL offscreen_in[%0d] got=%0d exp=%0d", i, in_sprite, tin[i]); end
      checks++; if (rom_address !== 17'(trm[i])) begin failures++; $display("FAIL offscreen_rom[%0d] got=%0d exp=%0d", i, rom_address, trm[i]); end
    end
  endtask

  task automatic test_reset_mid_action();
    clear_inputs(); do_reset();
    act_valid = 1; act_kind = 1; advance(); act_valid = 0;
    frame_tick = 1; repeat (10) advance();
    reset = 1'b1; #1;
    checks++; if (anim !== 3'd0) begin failures++; $display("FAIL midreset_anim got=%0d exp=0", anim); end
    @(posedge vga_clk); #1;
    checks++; if (act_done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%0d exp=0", act_done); end
    frame_tick = 0;
    do_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 6; c++) begin
      clear_inputs(); do_reset();
      for (int n = 0; n < 500; n++) begin
        frame_tick = ($urandom % 3) == 0;
        if (($urandom % 50) == 0) walk = ~walk;
        act_valid = ($urandom % 4) == 0;
        act_kind = 1'($urandom);
        hit = ($urandom % 60) == 0;
        health_zero = (c >= 3) && (($urandom % 400) == 0);
        facing_left = 1'($urandom);
        pos_x = 10'($urandom); pos_y = 10'($urandom);
        DrawX = 10'((int'(pos_x) + int'($urandom_range(0, 70)) - 3) & 1023);
        DrawY = 10'((int'(pos_y) + int'($urandom_range(0, 70)) - 3) & 1023);
        #1;
        checks++; if (act_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready[%0d] got=%0d exp=%0d", n, act_ready, m_ready()); end
        advance();
        checks++; if (anim !== 3'(m_anim)) begin failures++; $display("FAIL rnd_anim[%0d] got=%0d exp=%0d", n, anim, m_anim); end
        checks++; if (act_done !== m_done) begin failures++; $display("FAIL rnd_done[%0d] got=%0d exp=%0d", n, act_done, m_done); end
        checks++; if (in_sprite !== e_in) begin failures++; $display("FAIL rnd_in[%0d] got=%0d exp=%0d", n, in_sprite, e_in); end
        checks++; if (rom_address !== 17'(e_addr)) begin failures++; $display("FAIL rnd_rom[%0d] got=%0d exp=%0d", n, rom_address, e_addr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_punch();
    test_hit_during_kick();
    test_dead();
    test_addr();
    test_offscreen();
    test_reset_mid_action();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
